// File: rtl/nf1g_pkt_gen_pkg.sv
// nf1g_axis_pkt_gen shared types and constants.
// Build option: NF1G_PKT_GEN_LEN_SWEEP_EN (per-packet length sweep).
package nf1g_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [15:0] MIN_LEN = 16'd60;
  localparam logic [15:0] MAX_LEN = 16'd9600;

  localparam int TU_LEN_LSB = 0;
  localparam int TU_SRC_LSB = 16;
  localparam int TU_DST_LSB = 24;
  localparam int TU_SEQ_LSB = 32;

  // Force a requested length into the legal frame range
  function automatic logic [15:0] clamp_len(
    input logic [15:0] len
  );
    if (len < MIN_LEN)      return MIN_LEN;
    else if (len > MAX_LEN) return MAX_LEN;
    else                    return len;
  endfunction

endpackage

// File: rtl/nf1g_axis_pkt_gen_beat.sv
// Combinational beat former: (beat, len, seq) -> tdata/tstrb/tlast.
// Payload byte at offset i is i[7:0] + seq[7:0]; masked bytes are zero.
module nf1g_pkt_gen_beat
  import nf1g_pkt_gen_pkg::*;
#(
  parameter int DW = 256
) (
  input  logic [15:0]   i_beat,
  input  logic [15:0]   i_len,
  input  logic [7:0]    i_seq,
  output logic [DW-1:0] o_tdata,
  output logic [DW/8-1:0] o_tstrb,
  output logic          o_tlast
);

  localparam int W = DW / 8;

  logic [15:0] w_last;
  logic [15:0] w_rem;

  assign w_last = 16'((32'(i_len) - 32'd1) / 32'(W));
  assign w_rem  = 16'(32'(i_len) % 32'(W));

  // Strobe, last flag and byte pattern for one beat
  always_comb begin
    o_tlast = (i_beat == w_last);
    o_tstrb = '1;
    if (o_tlast && (w_rem != 16'd0)) begin
      for (int k = 0; k < W; k++) begin
        o_tstrb[k] = (16'(k) < w_rem);
      end
    end
    o_tdata = '0;
    for (int k = 0; k < W; k++) begin
      if (o_tstrb[k]) begin
        o_tdata[8*k +: 8] =
          8'(32'(i_beat) * 32'(W) + 32'(k)) + i_seq;
      end
    end
  end

endmodule

// File: rtl/nf1g_axis_pkt_gen.sv
// AXI4-Stream packet generator with NetFPGA tuser metadata.
// Build option: NF1G_PKT_GEN_LEN_SWEEP_EN enables length sweep.
module nf1g_axis_pkt_gen
  import nf1g_pkt_gen_pkg::*;
#(
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_SRC_PORT           = 8'h01,
  parameter logic [7:0] C_DST_PORT           = 8'h04,
  parameter int         C_LEN_SWEEP_MAX      = 1514
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stop,
  input  logic [15:0]                       num_pkts,
  input  logic [15:0]                       pkt_len,
  input  logic [7:0]                        ifg_cycles,
  output logic                              busy,
  output logic [31:0]                       pkt_count,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;

  state_t r_state;
  state_t w_state_nx;

  logic [15:0] r_beat;
  logic [15:0] r_len;
  logic [15:0] r_num;
  logic [15:0] r_sent;
  logic [7:0]  r_ifg;
  logic [7:0]  r_gap;
  logic [31:0] r_seq;
  logic [31:0] r_pkt_count;
  logic        r_busy;

  logic [DW-1:0] r_tdata;
  logic [SW-1:0] r_tstrb;
  logic [UW-1:0] r_tuser;
  logic          r_tvalid;
  logic          r_tlast;

  logic          w_hs;
  logic          w_eop;
  logic          w_run_end;
  logic          w_load;
  logic [15:0]   w_ld_beat;
  logic [15:0]   w_ld_len;
  logic [31:0]   w_ld_seq;
  logic [15:0]   w_len_nx;
  logic [DW-1:0] w_tdata;
  logic [SW-1:0] w_tstrb;
  logic          w_tlast;
  logic [UW-1:0] w_tuser;

  assign w_hs  = r_tvalid & m_axis_tready;
  assign w_eop = w_hs & r_tlast;
  assign w_run_end = stop |
    ((r_num != 16'd0) && ((r_sent + 16'd1) == r_num));

`ifdef NF1G_PKT_GEN_LEN_SWEEP_EN
  assign w_len_nx = (r_len >= 16'(C_LEN_SWEEP_MAX)) ?
                    MIN_LEN : r_len + 16'd1;
`else
  logic w_unused_sweep;
  assign w_unused_sweep = |16'(C_LEN_SWEEP_MAX);
  assign w_len_nx = r_len;
`endif

  // Next state and which beat (if any) to load into the output regs
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_ld_beat  = 16'd0;
    w_ld_len   = r_len;
    w_ld_seq   = r_seq;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = SEND;
          w_load     = 1'b1;
          w_ld_len   = clamp_len(pkt_len);
        end
      end
      SEND: begin
        if (w_hs) begin
          if (!r_tlast) begin
            w_load    = 1'b1;
            w_ld_beat = r_beat + 16'd1;
          end else if (w_run_end) begin
            w_state_nx = IDLE;
          end else if (r_ifg != 8'd0) begin
            w_state_nx = GAP;
          end else begin
            w_load   = 1'b1;
            w_ld_len = w_len_nx;
            w_ld_seq = r_seq + 32'd1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          w_state_nx = IDLE;
        end else if (r_gap == 8'd1) begin
          w_state_nx = SEND;
          w_load     = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  nf1g_pkt_gen_beat #(
    .DW(DW)
  ) u_beat (
    .i_beat  (w_ld_beat),
    .i_len   (w_ld_len),
    .i_seq   (w_ld_seq[7:0]),
    .o_tdata (w_tdata),
    .o_tstrb (w_tstrb),
    .o_tlast (w_tlast)
  );

  // Metadata for the beat being loaded
  always_comb begin
    w_tuser = '0;
    w_tuser[TU_LEN_LSB +: 16] = w_ld_len;
    w_tuser[TU_SRC_LSB +: 8]  = C_SRC_PORT;
    w_tuser[TU_DST_LSB +: 8]  = C_DST_PORT;
    w_tuser[TU_SEQ_LSB +: 32] = w_ld_seq;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Run parameters, counters and registered AXIS outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat      <= 16'd0;
      r_len       <= 16'd0;
      r_num       <= 16'd0;
      r_sent      <= 16'd0;
      r_ifg       <= 8'd0;
      r_gap       <= 8'd0;
      r_seq       <= 32'd0;
      r_pkt_count <= 32'd0;
      r_busy      <= 1'b0;
      r_tdata     <= '0;
      r_tstrb     <= '0;
      r_tuser     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
    end else begin
      r_busy <= (w_state_nx != IDLE);
      if ((r_state == IDLE) && start) begin
        r_num  <= num_pkts;
        r_ifg  <= ifg_cycles;
        r_sent <= 16'd0;
        r_len  <= clamp_len(pkt_len);
      end
      if (w_eop) begin
        r_pkt_count <= r_pkt_count + 32'd1;
        r_seq       <= r_seq + 32'd1;
        r_sent      <= r_sent + 16'd1;
        r_len       <= w_len_nx;
      end
      if (w_eop && (w_state_nx == GAP)) begin
        r_gap <= r_ifg;
      end else if (r_state == GAP) begin
        r_gap <= r_gap - 8'd1;
      end
      if (w_load) begin
        r_beat   <= w_ld_beat;
        r_tvalid <= 1'b1;
        r_tdata  <= w_tdata;
        r_tstrb  <= w_tstrb;
        r_tuser  <= w_tuser;
        r_tlast  <= w_tlast;
      end else if (w_eop) begin
        r_tvalid <= 1'b0;
        r_tdata  <= '0;
        r_tstrb  <= '0;
        r_tuser  <= '0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign busy          = r_busy;
  assign pkt_count     = r_pkt_count;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tstrb  = r_tstrb;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_nf1g_axis_pkt_gen.sv
// Self-checking bench for nf1g_axis_pkt_gen (default build).
// Directed vector table plus multi-cycle corner sequences.
module tb_nf1g_axis_pkt_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [15:0]  num_pkts = 16'd0;
  logic [15:0]  pkt_len = 16'd0;
  logic [7:0]   ifg_cycles = 8'd0;
  logic         busy;
  logic [31:0]  pkt_count;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;

  nf1g_axis_pkt_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .num_pkts      (num_pkts),
    .pkt_len       (pkt_len),
    .ifg_cycles    (ifg_cycles),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  typedef struct {
    int          num;
    int          len;
    int          ifg;
    int          beats;
    int          exp_len;
    logic [31:0] strb;
    logic [7:0]  b0;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  int    gaps[$];
  int    gap_run = 0;
  bit    stall_en = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_b;
  beat_t cur_b;
  beat_t last_b;
  vec_t  vt[7];

  always @(negedge clk) begin
    cur_b = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    if (prev_stall) begin
      checks++;
      if (!m_axis_tvalid || (cur_b !== prev_b)) begin
        errors++;
        $display("FAIL stall_hold: got v=%b u=%h want v=1 u=%h",
                 m_axis_tvalid, cur_b.u, prev_b.u);
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready && !reset;
    prev_b = cur_b;
    if (m_axis_tvalid && m_axis_tready) q.push_back(cur_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic do_start(input int num, input int len, input int ifg);
    num_pkts   = 16'(num);
    pkt_len    = 16'(len);
    ifg_cycles = 8'(ifg);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_beat_latency", 256'(m_axis_tvalid), 256'd1);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    do begin
      tick();
      m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy && !m_axis_tvalid) begin
        gap_run++;
      end else if (m_axis_tvalid && gap_run != 0) begin
        gaps.push_back(gap_run);
        gap_run = 0;
      end
      n++;
    end while (busy && n < lim);
    m_axis_tready = 1'b1;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles want 0",
               nm, n);
    end
  endtask

  task automatic check_pkt(input string nm, input int sq, input int len);
    int nb;
    beat_t b;
    beat_t e;
    nb = (len + 31) / 32;
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s_beat%0d: got none want a beat", nm, i);
        return;
      end
      b = q.pop_front();
      e = '0;
      for (int k = 0; k < 32; k++) begin
        if (i * 32 + k < len) begin
          e.s[k] = 1'b1;
          e.d[8*k +: 8] = 8'(i * 32 + k + sq);
        end
      end
      e.l = (i == nb - 1);
      e.u[15:0]  = 16'(len);
      e.u[23:16] = 8'h01;
      e.u[31:24] = 8'h04;
      e.u[63:32] = 32'(sq);
      if (b !== e) begin
        errors++;
        $display("FAIL %s_beat%0d: got d=%h s=%h u=%h l=%b want d=%h s=%h u=%h l=%b",
                 nm, i, b.d, b.s, b.u, b.l, e.d, e.s, e.u, e.l);
      end
      last_b = b;
    end
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 64,   0, 2,   64,   32'hFFFFFFFF, 8'h20};
    vt[1] = '{1, 65,   0, 3,   65,   32'h00000001, 8'h40};
    vt[2] = '{1, 20,   0, 2,   60,   32'h0FFFFFFF, 8'h20};
    vt[3] = '{1, 61,   0, 2,   61,   32'h1FFFFFFF, 8'h20};
    vt[4] = '{1, 96,   0, 3,   96,   32'hFFFFFFFF, 8'h40};
    vt[5] = '{1, 100,  0, 4,   100,  32'h0000000F, 8'h60};
    vt[6] = '{1, 9999, 0, 300, 9600, 32'hFFFFFFFF, 8'h60};

    // reset state, sampled while reset is held
    reset = 1'b1;
    repeat (50) tick();
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
    chk("rst_tlast", 256'(m_axis_tlast), 256'd0);
    chk("rst_tdata", m_axis_tdata, 256'd0);
    chk("rst_tstrb", 256'(m_axis_tstrb), 256'd0);
    chk("rst_tuser", 256'(m_axis_tuser), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_pkt_count", 256'(pkt_count), 256'd0);
    reset = 1'b0;

    // single-packet table
    for (int v = 0; v < 7; v++) begin
      apply_reset(4);
      do_start(vt[v].num, vt[v].len, vt[v].ifg);
      wait_idle("vec", 400);
      chk("vec_beats", 256'(q.size()), 256'(vt[v].beats));
      check_pkt("vec", 0, vt[v].exp_len);
      chk("vec_last_strb", 256'(last_b.s), 256'(vt[v].strb));
      chk("vec_last_byte0", 256'(last_b.d[7:0]), 256'(vt[v].b0));
      chk("vec_len_field", 256'(last_b.u[15:0]), 256'(vt[v].exp_len));
      chk("vec_pkt_count", 256'(pkt_count), 256'd1);
      chk("vec_busy", 256'(busy), 256'd0);
    end

    // random tready stalls over four packets
    apply_reset(4);
    stall_en = 1'b1;
    do_start(4, 100, 0);
    wait_idle("stall", 300);
    stall_en = 1'b0;
    chk("stall_beats", 256'(q.size()), 256'd16);
    for (int s = 0; s < 4; s++) check_pkt("stall", s, 100);
    chk("stall_pkt_count", 256'(pkt_count), 256'd4);

    // inter-frame gap of four cycles, none after the last packet
    apply_reset(4);
    gaps.delete();
    gap_run = 0;
    do_start(3, 64, 4);
    wait_idle("gap", 100);
    chk("gap_count", 256'(gaps.size()), 256'd2);
    for (int i = 0; i < gaps.size(); i++)
      chk("gap_len", 256'(gaps[i]), 256'd4);
    chk("gap_trailing", 256'(gap_run), 256'd0);
    for (int s = 0; s < 3; s++) check_pkt("gap", s, 64);
    chk("gap_pkt_count", 256'(pkt_count), 256'd3);

    // continuous run, stop mid-packet; start while busy ignored
    apply_reset(4);
    do_start(0, 200, 0);
    pkt_len = 16'd64;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1;
    wait_idle("stop", 100);
    stop = 1'b0;
    chk("stop_beats", 256'(q.size()), 256'd7);
    check_pkt("stop", 0, 200);
    chk("stop_tlast", 256'(last_b.l), 256'd1);
    chk("stop_pkt_count", 256'(pkt_count), 256'd1);

    // reset while the second beat of a 200-byte packet is presented
    do_start(1, 200, 0);
    tick();
    chk("mid_beat2_len", 256'(m_axis_tuser[15:0]), 256'd200);
    reset = 1'b1;
    tick();
    chk("mid_rst_tvalid", 256'(m_axis_tvalid), 256'd0);
    chk("mid_rst_pkt_count", 256'(pkt_count), 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    reset = 1'b0;
    q.delete();
    do_start(1, 64, 0);
    chk("post_rst_seq", 256'(m_axis_tuser[63:32]), 256'd0);
    wait_idle("post_rst", 50);
    check_pkt("post_rst", 0, 64);
    chk("post_rst_pkt_count", 256'(pkt_count), 256'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
